// File: rtl/tfhe_pu_ctrl_regs_pkg.sv
// tfhe_pu_regs_pkg: shared definitions for the TFHE PU control/status register block.
//   - byte offsets of every register in the map
//   - bit positions inside CTRL and STATUS
//   - AXI response codes
//   - write/read FSM state types
package tfhe_pu_regs_pkg;

    localparam int unsigned OFF_ID      = 32'h00;
    localparam int unsigned OFF_CTRL    = 32'h04;
    localparam int unsigned OFF_STATUS  = 32'h08;
    localparam int unsigned OFF_LED     = 32'h0C;
    localparam int unsigned OFF_SCRATCH = 32'h10;
    localparam int unsigned OFF_CNT_LO  = 32'h18;
    localparam int unsigned OFF_CNT_HI  = 32'h1C;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_IRQ_EN_BIT  = 1;
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_DONE_BIT  = 1;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/tfhe_pu_ctrl_regs_if.sv
// tfhe_pu_ctrl_regs_if: AXI4-Lite bundle between the XDMA bridge master and the
// register block.
//   master modport: drives AW/W/AR payloads and valids, bready, rready.
//   slave modport : drives awready/wready/arready, B and R channels.
interface tfhe_pu_ctrl_regs_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/tfhe_pu_ctrl_regs_wr_collect.sv
// tfhe_pu_axil_wr_collect: AW/W holding registers plus the AXI-Lite write FSM.
//   clk, rst                      : clock, async active-high reset
//   awaddr/awvalid/awready        : AW channel
//   wdata/wstrb/wvalid/wready     : W channel
//   bresp/bvalid/bready           : B channel
//   commit, commit_addr/data/strb : one-cycle write strobe to the register file
//   commit_resp                   : decode result for commit_addr, latched into bresp
//
// State table
//   W_COLLECT | accepting AW and W independently; commit when both are available
//   W_RESP    | bvalid held until bready, no new AW/W accepted
module tfhe_pu_axil_wr_collect
    import tfhe_pu_regs_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  commit,
    output logic [ADDR_WIDTH-1:0] commit_addr,
    output logic [31:0]           commit_data,
    output logic [3:0]            commit_strb,
    input  axi_resp_e             commit_resp
);

    wr_state_e             state;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;
    logic                  aw_have;
    logic                  w_have;

    // In W_COLLECT a low ready means that channel's holding register is full.
    // The commit fires in the same cycle the second channel handshakes, taking
    // the live bus value for whichever channel is still being accepted.
    always_comb begin
        aw_have     = !awready || awvalid;
        w_have      = !wready || wvalid;
        commit      = (state == W_COLLECT) && aw_have && w_have;
        commit_addr = awready ? awaddr : aw_addr_q;
        commit_data = wready ? wdata : w_data_q;
        commit_strb = wready ? wstrb : w_strb_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= W_COLLECT;
            awready   <= 1'b1;
            wready    <= 1'b1;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            case (state)
                W_COLLECT: begin
                    if (awready && awvalid) aw_addr_q <= awaddr;
                    if (wready && wvalid) begin
                        w_data_q <= wdata;
                        w_strb_q <= wstrb;
                    end
                    if (commit) begin
                        state   <= W_RESP;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        bresp   <= commit_resp;
                    end else begin
                        if (awvalid) awready <= 1'b0;
                        if (wvalid)  wready  <= 1'b0;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        state   <= W_COLLECT;
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                    end
                end
                default: state <= W_COLLECT;
            endcase
        end
    end

endmodule

// File: rtl/tfhe_pu_ctrl_regs.sv
// tfhe_pu_ctrl_regs: AXI4-Lite register block for the TFHE PU (ID, CTRL,
// STATUS, LED, SCRATCH), driving LEDs, the PU start pulse and the interrupt.
//   sys_clk, sys_rst : clock, async active-high reset
//   s_axil           : AXI-Lite slave (tfhe_pu_ctrl_regs_if.slave)
//   pu_busy, pu_done : PU busy level and completion pulse
//   pu_start, irq    : one-cycle start pulse, level interrupt
//   leds             : board LEDs
// Optional: define TFHE_PU_REGS_CYCLE_CNT_EN to add a 64-bit cycle counter at
// 0x18 (low word, snapshots high) / 0x1C (snapshot); otherwise both are unmapped.
//
// State table (read path)
//   R_IDLE | arready high, waiting for arvalid
//   R_DATA | rvalid high with stable payload until rready
module tfhe_pu_ctrl_regs
    import tfhe_pu_regs_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] ID_VALUE   = 32'h5446_4845,
    parameter int          LED_WIDTH  = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    tfhe_pu_ctrl_regs_if.slave   s_axil,
    input  logic                 pu_busy,
    input  logic                 pu_done,
    output logic                 pu_start,
    output logic                 irq,
    output logic [LED_WIDTH-1:0] leds
);

    function automatic logic hit(input logic [ADDR_WIDTH-1:0] addr, input int unsigned off);
        logic [ADDR_WIDTH-1:0] a;
        a      = addr;
        a[1:0] = 2'b00;
        return a == ADDR_WIDTH'(off);
    endfunction

    logic                  commit;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [31:0]           c_data;
    logic [3:0]            c_strb;
    logic [31:0]           c_mask;
    axi_resp_e             wr_resp;

    tfhe_pu_axil_wr_collect #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .awaddr      (s_axil.awaddr),
        .awvalid     (s_axil.awvalid),
        .awready     (s_axil.awready),
        .wdata       (s_axil.wdata),
        .wstrb       (s_axil.wstrb),
        .wvalid      (s_axil.wvalid),
        .wready      (s_axil.wready),
        .bresp       (s_axil.bresp),
        .bvalid      (s_axil.bvalid),
        .bready      (s_axil.bready),
        .commit      (commit),
        .commit_addr (c_addr),
        .commit_data (c_data),
        .commit_strb (c_strb),
        .commit_resp (wr_resp)
    );

    logic                 irq_en;
    logic                 done;
    logic                 busy_q;
    logic [LED_WIDTH-1:0] led_q;
    logic [31:0]          scratch;
    logic                 wr_ctrl, wr_status, wr_led, wr_scratch;

    assign c_mask     = {{8{c_strb[3]}}, {8{c_strb[2]}}, {8{c_strb[1]}}, {8{c_strb[0]}}};
    assign wr_ctrl    = commit && hit(c_addr, OFF_CTRL);
    assign wr_status  = commit && hit(c_addr, OFF_STATUS);
    assign wr_led     = commit && hit(c_addr, OFF_LED);
    assign wr_scratch = commit && hit(c_addr, OFF_SCRATCH);
    assign leds       = led_q;

    // ID writes are accepted and dropped; only truly unmapped offsets error.
    always_comb begin
        wr_resp = RESP_SLVERR;
        if (hit(c_addr, OFF_ID) || hit(c_addr, OFF_CTRL) || hit(c_addr, OFF_STATUS) ||
            hit(c_addr, OFF_LED) || hit(c_addr, OFF_SCRATCH))
            wr_resp = RESP_OKAY;
`ifdef TFHE_PU_REGS_CYCLE_CNT_EN
        if (hit(c_addr, OFF_CNT_LO) || hit(c_addr, OFF_CNT_HI))
            wr_resp = RESP_OKAY;
`endif
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            irq_en   <= 1'b0;
            done     <= 1'b0;
            busy_q   <= 1'b0;
            led_q    <= '0;
            scratch  <= '0;
            pu_start <= 1'b0;
            irq      <= 1'b0;
        end else begin
            busy_q   <= pu_busy;
            pu_start <= wr_ctrl && c_strb[0] && c_data[CTRL_START_BIT];
            if (wr_ctrl && c_strb[0]) irq_en <= c_data[CTRL_IRQ_EN_BIT];
            // A completion pulse beats a simultaneous write-1-to-clear.
            if (pu_done)
                done <= 1'b1;
            else if (wr_status && c_strb[0] && c_data[STATUS_DONE_BIT])
                done <= 1'b0;
            irq <= irq_en & done;
            if (wr_led)
                led_q <= (led_q & ~c_mask[LED_WIDTH-1:0]) | (c_data[LED_WIDTH-1:0] & c_mask[LED_WIDTH-1:0]);
            if (wr_scratch)
                scratch <= (scratch & ~c_mask) | (c_data & c_mask);
        end
    end

    logic ar_fire;
    assign ar_fire = s_axil.arready && s_axil.arvalid;

`ifdef TFHE_PU_REGS_CYCLE_CNT_EN
    logic [63:0] cyc_cnt;
    logic [31:0] cnt_hi_snap;

    // Reading the low word freezes the high word so the pair is coherent.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cyc_cnt     <= '0;
            cnt_hi_snap <= '0;
        end else begin
            if (commit && hit(c_addr, OFF_CNT_LO))
                cyc_cnt <= '0;
            else
                cyc_cnt <= cyc_cnt + 64'd1;
            if (ar_fire && hit(s_axil.araddr, OFF_CNT_LO))
                cnt_hi_snap <= cyc_cnt[63:32];
        end
    end
`endif

    logic [31:0] rd_data;
    axi_resp_e   rd_resp;

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        if (hit(s_axil.araddr, OFF_ID))
            rd_data = ID_VALUE;
        else if (hit(s_axil.araddr, OFF_CTRL))
            rd_data[CTRL_IRQ_EN_BIT] = irq_en;
        else if (hit(s_axil.araddr, OFF_STATUS)) begin
            rd_data[STATUS_BUSY_BIT] = busy_q;
            rd_data[STATUS_DONE_BIT] = done;
        end
        else if (hit(s_axil.araddr, OFF_LED))
            rd_data[LED_WIDTH-1:0] = led_q;
        else if (hit(s_axil.araddr, OFF_SCRATCH))
            rd_data = scratch;
`ifdef TFHE_PU_REGS_CYCLE_CNT_EN
        else if (hit(s_axil.araddr, OFF_CNT_LO))
            rd_data = cyc_cnt[31:0];
        else if (hit(s_axil.araddr, OFF_CNT_HI))
            rd_data = cnt_hi_snap;
`endif
        else
            rd_resp = RESP_SLVERR;
    end

    rd_state_e rd_state;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_state       <= R_IDLE;
            s_axil.arready <= 1'b1;
            s_axil.rvalid  <= 1'b0;
            s_axil.rdata   <= '0;
            s_axil.rresp   <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        rd_state       <= R_DATA;
                        s_axil.arready <= 1'b0;
                        s_axil.rvalid  <= 1'b1;
                        s_axil.rdata   <= rd_data;
                        s_axil.rresp   <= rd_resp;
                    end
                end
                R_DATA: begin
                    if (s_axil.rready) begin
                        rd_state       <= R_IDLE;
                        s_axil.rvalid  <= 1'b0;
                        s_axil.arready <= 1'b1;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tfhe_pu_ctrl_regs.sv
`timescale 1ns/1ps
module tb_tfhe_pu_ctrl_regs;
    import tfhe_pu_regs_pkg::*;

    localparam int          AW = 12;
    localparam logic [31:0] ID = 32'h5446_4845;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       pu_busy = 1'b0;
    logic       pu_done = 1'b0;
    logic       pu_start;
    logic       irq;
    logic [7:0] leds;

    tfhe_pu_ctrl_regs_if #(.ADDR_WIDTH(AW)) axil();

    tfhe_pu_ctrl_regs #(.ADDR_WIDTH(AW), .ID_VALUE(ID), .LED_WIDTH(8)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .s_axil   (axil),
        .pu_busy  (pu_busy),
        .pu_done  (pu_done),
        .pu_start (pu_start),
        .irq      (irq),
        .leds     (leds)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int          start_cnt = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;
    always @(negedge sys_clk) if (pu_start) start_cnt <= start_cnt + 1;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit with_done, output logic [1:0] resp);
        bit aw_hs, w_hs;
        int t;
        axil.awaddr  = a;
        axil.awvalid = 1'b1;
        axil.wdata   = d;
        axil.wstrb   = s;
        axil.wvalid  = 1'b1;
        if (with_done) pu_done = 1'b1;
        t = 0;
        while ((axil.awvalid || axil.wvalid) && t < 20) begin
            aw_hs = axil.awvalid && axil.awready;
            w_hs  = axil.wvalid && axil.wready;
            @(posedge sys_clk); #1;
            pu_done = 1'b0;
            if (aw_hs) axil.awvalid = 1'b0;
            if (w_hs)  axil.wvalid  = 1'b0;
            t++;
        end
        axil.awvalid = 1'b0;
        axil.wvalid  = 1'b0;
        t = 0;
        while (!axil.bvalid && t < 20) begin
            @(posedge sys_clk); #1;
            t++;
        end
        check("wr_bvalid_latency", t, 0);
        resp = axil.bresp;
        axil.bready = 1'b1;
        @(posedge sys_clk); #1;
        axil.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int t;
        t = 0;
        axil.araddr  = a;
        axil.arvalid = 1'b1;
        while (!axil.arready && t < 20) begin
            @(posedge sys_clk); #1;
            t++;
        end
        check("rd_arready_wait", t, 0);
        @(posedge sys_clk); #1;
        axil.arvalid = 1'b0;
        check("rd_rvalid_latency", {31'b0, axil.rvalid}, 32'd1);
        d    = axil.rdata;
        resp = axil.rresp;
        axil.rready = 1'b1;
        @(posedge sys_clk); #1;
        axil.rready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [AW-1:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic [7:0]  exp_leds;
    } vec_t;

    function automatic vec_t mk(bit wr, logic [AW-1:0] a, logic [31:0] d, logic [3:0] s,
                                logic [31:0] er, logic [1:0] rs, logic [7:0] el);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s;
        v.exp_rdata = er; v.exp_resp = rs; v.exp_leds = el;
        return v;
    endfunction

    vec_t        vecs[$];
    logic [31:0] rd;
    logic [1:0]  resp;
    logic [1:0]  resp2;
    int          base;
    int unsigned c0, c1;

    initial begin
        axil.awaddr = '0; axil.awvalid = 1'b0; axil.wdata = '0; axil.wstrb = '0;
        axil.wvalid = 1'b0; axil.bready = 1'b0; axil.araddr = '0; axil.arvalid = 1'b0;
        axil.rready = 1'b0;

        vecs.push_back(mk(0, 12'h000, 32'h0,         4'hF, ID,            RESP_OKAY,   8'h00));
        vecs.push_back(mk(1, 12'h010, 32'hDEADBEEF,  4'hF, 32'h0,         RESP_OKAY,   8'h00));
        vecs.push_back(mk(1, 12'h010, 32'h11223344,  4'h4, 32'h0,         RESP_OKAY,   8'h00));
        vecs.push_back(mk(0, 12'h010, 32'h0,         4'hF, 32'hDE22BEEF,  RESP_OKAY,   8'h00));
        vecs.push_back(mk(1, 12'h00C, 32'h000001C3,  4'hF, 32'h0,         RESP_OKAY,   8'hC3));
        vecs.push_back(mk(0, 12'h00C, 32'h0,         4'hF, 32'h000000C3,  RESP_OKAY,   8'hC3));
        vecs.push_back(mk(1, 12'h00C, 32'hFFFF5A00,  4'h2, 32'h0,         RESP_OKAY,   8'hC3));
        vecs.push_back(mk(0, 12'h00F, 32'h0,         4'hF, 32'h000000C3,  RESP_OKAY,   8'hC3));
        vecs.push_back(mk(1, 12'h000, 32'h12345678,  4'hF, 32'h0,         RESP_OKAY,   8'hC3));
        vecs.push_back(mk(0, 12'h000, 32'h0,         4'hF, ID,            RESP_OKAY,   8'hC3));
        vecs.push_back(mk(1, 12'h040, 32'hFFFFFFFF,  4'hF, 32'h0,         RESP_SLVERR, 8'hC3));
        vecs.push_back(mk(0, 12'h040, 32'h0,         4'hF, 32'h0,         RESP_SLVERR, 8'hC3));
        vecs.push_back(mk(0, 12'h014, 32'h0,         4'hF, 32'h0,         RESP_SLVERR, 8'hC3));
        vecs.push_back(mk(1, 12'h3FC, 32'hFFFFFFFF,  4'hF, 32'h0,         RESP_SLVERR, 8'hC3));
        vecs.push_back(mk(0, 12'h010, 32'h0,         4'hF, 32'hDE22BEEF,  RESP_OKAY,   8'hC3));
        vecs.push_back(mk(1, 12'h004, 32'h00000002,  4'hF, 32'h0,         RESP_OKAY,   8'hC3));
        vecs.push_back(mk(0, 12'h004, 32'h0,         4'hF, 32'h00000002,  RESP_OKAY,   8'hC3));
        vecs.push_back(mk(1, 12'h004, 32'h00000000,  4'h0, 32'h0,         RESP_OKAY,   8'hC3));
        vecs.push_back(mk(0, 12'h004, 32'h0,         4'hF, 32'h00000002,  RESP_OKAY,   8'hC3));
        vecs.push_back(mk(1, 12'h004, 32'h00000000,  4'h1, 32'h0,         RESP_OKAY,   8'hC3));
        vecs.push_back(mk(0, 12'h004, 32'h0,         4'hF, 32'h00000000,  RESP_OKAY,   8'hC3));
        vecs.push_back(mk(0, 12'h008, 32'h0,         4'hF, 32'h00000000,  RESP_OKAY,   8'hC3));
`ifdef TFHE_PU_REGS_CYCLE_CNT_EN
        vecs.push_back(mk(0, 12'h01C, 32'h0,         4'hF, 32'h00000000,  RESP_OKAY,   8'hC3));
`else
        vecs.push_back(mk(0, 12'h018, 32'h0,         4'hF, 32'h0,         RESP_SLVERR, 8'hC3));
        vecs.push_back(mk(0, 12'h01C, 32'h0,         4'hF, 32'h0,         RESP_SLVERR, 8'hC3));
        vecs.push_back(mk(1, 12'h018, 32'h0,         4'hF, 32'h0,         RESP_SLVERR, 8'hC3));
`endif

        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_ready", {29'b0, axil.awready, axil.wready, axil.arready}, 32'h7);
        check("rst_valid", {30'b0, axil.bvalid, axil.rvalid}, 32'h0);
        check("rst_resp_rdata", axil.rdata | {28'b0, axil.bresp, axil.rresp}, 32'h0);
        check("rst_outputs", {22'b0, pu_start, irq, leds}, 32'h0);
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 1'b0, resp);
                check($sformatf("v%0d_bresp", i), resp, vecs[i].exp_resp);
            end else begin
                axi_read(vecs[i].addr, rd, resp);
                check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
                check($sformatf("v%0d_rresp", i), resp, vecs[i].exp_resp);
            end
            check($sformatf("v%0d_leds", i), leds, vecs[i].exp_leds);
        end

        // W presented three cycles ahead of AW
        axil.wdata = 32'h000000A5; axil.wstrb = 4'b0001; axil.wvalid = 1'b1;
        check("wfirst_wready", axil.wready, 1'b1);
        @(posedge sys_clk); #1;
        axil.wvalid = 1'b0;
        repeat (2) begin
            check("wfirst_wready_held", axil.wready, 1'b0);
            check("wfirst_no_bvalid", axil.bvalid, 1'b0);
            @(posedge sys_clk); #1;
        end
        axil.awaddr = 12'h00C; axil.awvalid = 1'b1;
        check("wfirst_awready", axil.awready, 1'b1);
        @(posedge sys_clk); #1;
        axil.awvalid = 1'b0;
        check("wfirst_bvalid", axil.bvalid, 1'b1);
        check("wfirst_bresp", axil.bresp, RESP_OKAY);
        check("wfirst_leds", leds, 8'hA5);
        axil.bready = 1'b1;
        @(posedge sys_clk); #1;
        axil.bready = 1'b0;
        check("wfirst_reopen", {30'b0, axil.awready, axil.wready}, 32'h3);
        check("wfirst_bvalid_clr", axil.bvalid, 1'b0);
        axi_read(12'h00C, rd, resp);
        check("wfirst_readback", rd, 32'h000000A5);

        // START pulse and IRQ_EN
        base = start_cnt;
        axi_write(12'h004, 32'h3, 4'hF, 1'b0, resp);
        repeat (3) @(posedge sys_clk);
        #1;
        check("start_pulse_count", start_cnt - base, 1);
        axi_read(12'h004, rd, resp);
        check("ctrl_start_reads0", rd, 32'h2);

        // DONE set, irq one cycle behind
        pu_done = 1'b1;
        @(posedge sys_clk); #1;
        pu_done = 1'b0;
        check("irq_lag", irq, 1'b0);
        @(posedge sys_clk); #1;
        check("irq_set", irq, 1'b1);
        axi_read(12'h008, rd, resp);
        check("status_done", rd, 32'h2);
        axi_write(12'h008, 32'h2, 4'hF, 1'b1, resp);
        axi_read(12'h008, rd, resp);
        check("done_set_wins", rd, 32'h2);
        check("irq_still_set", irq, 1'b1);
        axi_write(12'h008, 32'h2, 4'hF, 1'b0, resp);
        axi_read(12'h008, rd, resp);
        check("done_w1c", rd, 32'h0);
        check("irq_cleared", irq, 1'b0);

        // IRQ_EN gating and START only with strobe and data bit
        pu_done = 1'b1;
        @(posedge sys_clk); #1;
        pu_done = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("irq_reset_again", irq, 1'b1);
        base = start_cnt;
        axi_write(12'h004, 32'h1, 4'h0, 1'b0, resp);
        axi_write(12'h004, 32'h0, 4'hF, 1'b0, resp);
        repeat (2) @(posedge sys_clk);
        #1;
        check("no_start_pulse", start_cnt - base, 0);
        check("irq_gated", irq, 1'b0);

        // BUSY sampled
        pu_busy = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        axi_read(12'h008, rd, resp);
        check("status_busy_done", rd, 32'h3);
        pu_busy = 1'b0;

        // B stall on an unmapped write
        axil.awaddr = 12'h040; axil.awvalid = 1'b1;
        axil.wdata = 32'h12345678; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
        @(posedge sys_clk); #1;
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        repeat (5) begin
            check("bstall_bvalid", axil.bvalid, 1'b1);
            check("bstall_bresp", axil.bresp, RESP_SLVERR);
            check("bstall_ready_low", {30'b0, axil.awready, axil.wready}, 32'h0);
            @(posedge sys_clk); #1;
        end
        axil.bready = 1'b1;
        @(posedge sys_clk); #1;
        axil.bready = 1'b0;
        check("bstall_release", {30'b0, axil.bvalid, axil.awready}, 32'h1);

        // R stall
        axil.araddr = 12'h000; axil.arvalid = 1'b1;
        @(posedge sys_clk); #1;
        axil.arvalid = 1'b0;
        repeat (5) begin
            check("rstall_rvalid", axil.rvalid, 1'b1);
            check("rstall_rdata", axil.rdata, ID);
            check("rstall_arready", axil.arready, 1'b0);
            @(posedge sys_clk); #1;
        end
        axil.rready = 1'b1;
        @(posedge sys_clk); #1;
        axil.rready = 1'b0;
        check("rstall_release", {30'b0, axil.rvalid, axil.arready}, 32'h1);

        // Simultaneous read and write of SCRATCH: read sees pre-write value
        fork
            axi_write(12'h010, 32'h0BADF00D, 4'hF, 1'b0, resp2);
            axi_read(12'h010, rd, resp);
        join
        check("rw_same_old", rd, 32'hDE22BEEF);
        axi_read(12'h010, rd, resp);
        check("rw_same_new", rd, 32'h0BADF00D);

`ifdef TFHE_PU_REGS_CYCLE_CNT_EN
        axil.awaddr = 12'h018; axil.awvalid = 1'b1;
        axil.wdata = 32'hFFFFFFFF; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
        @(posedge sys_clk); #1;
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        c0 = cyc;
        check("cnt_clr_bresp", {31'b0, axil.bvalid}, 32'd1);
        axil.bready = 1'b1;
        @(posedge sys_clk); #1;
        axil.bready = 1'b0;
        repeat (100) @(posedge sys_clk);
        #1;
        axil.araddr = 12'h018; axil.arvalid = 1'b1;
        c1 = cyc;
        @(posedge sys_clk); #1;
        axil.arvalid = 1'b0;
        check("cnt_lo", axil.rdata, c1 - c0);
        check("cnt_lo_resp", axil.rresp, RESP_OKAY);
        axil.rready = 1'b1;
        @(posedge sys_clk); #1;
        axil.rready = 1'b0;
        axi_read(12'h01C, rd, resp);
        check("cnt_hi", rd, 32'h0);
`endif

        // Async reset aborts an outstanding response
        axil.awaddr = 12'h040; axil.awvalid = 1'b1;
        axil.wdata = 32'h0; axil.wstrb = 4'hF; axil.wvalid = 1'b1;
        @(posedge sys_clk); #1;
        axil.awvalid = 1'b0; axil.wvalid = 1'b0;
        check("abort_pending", axil.bvalid, 1'b1);
        sys_rst = 1'b1;
        #1;
        check("abort_bvalid", {30'b0, axil.bvalid, axil.awready}, 32'h1);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        axi_read(12'h010, rd, resp);
        check("abort_scratch_cleared", rd, 32'h0);
        check("abort_leds_cleared", leds, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
